// File: rtl/sqrt2_driver.sv
// sqrt2_driver: operand FIFO plus one-at-a-time sequencer for the bus-level FP16 square-root unit.
// Optional WAIT-state watchdog is compiled in when SQRT_DRV_TIMEOUT_EN is defined.
module sqrt2_driver #(
  parameter int FIFO_DEPTH  = 4,
  parameter int OP_HOLD     = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [15:0] OUT_DATA,
  output logic [2:0]  OUT_FLAGS,
  output logic        OUT_TIMEOUT,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  inout  wire  [15:0] SQ_DATA,
  output logic        SQ_ENABLE,
  input  logic        SQ_RESULT,
  input  logic        SQ_IS_NAN,
  input  logic        SQ_IS_PINF,
  input  logic        SQ_IS_NINF
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [1:0]    HOLD_LAST = 2'(OP_HOLD - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sqrt2_driver: FIFO_DEPTH must be a power of two >= 2");
  end
  if (OP_HOLD < 1 || OP_HOLD > 3 || TIMEOUT_CYC < 2) begin : g_bad_timing
    $error("sqrt2_driver: OP_HOLD must be 1..3 and TIMEOUT_CYC >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_DRIVE   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_PRESENT = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_op;
  logic [1:0]      r_hold_cnt;
  logic            r_sq_en;
  logic            r_drive;
  logic [15:0]     r_out_data;
  logic [2:0]      r_out_flags;
  logic            r_out_valid;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_to_hit;
  logic            w_abort;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == {CW{1'b0}});
  assign IN_READY = !RESET && !w_full;
  assign w_push   = IN_VALID && IN_READY;
  assign w_pop    = (r_state == S_IDLE) && !w_empty && !RESET;

  // Operand storage; contents are don't-care until a push writes them.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= IN_DATA;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SQRT_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  logic [TW-1:0] r_to_cnt;
  logic          r_to_flag;
  logic          r_out_timeout;

  // Watchdog counts WAIT cycles; it sits at zero outside WAIT so every entry starts fresh.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_to_cnt <= {TW{1'b0}};
    end else if (r_state == S_WAIT) begin
      r_to_cnt <= r_to_cnt + TO_ONE;
    end else begin
      r_to_cnt <= {TW{1'b0}};
    end
  end

  // Remembers that the current transaction left WAIT through the watchdog.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_to_flag <= 1'b0;
    end else if (r_state == S_WAIT && !SQ_RESULT && w_to_hit) begin
      r_to_flag <= 1'b1;
    end else if (r_state == S_ARM) begin
      r_to_flag <= 1'b0;
    end else begin
      r_to_flag <= r_to_flag;
    end
  end

  // Timeout indication travels with the captured result.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_out_timeout <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      r_out_timeout <= r_to_flag;
    end else begin
      r_out_timeout <= r_out_timeout;
    end
  end

  assign w_to_hit    = (r_to_cnt == TO_LAST);
  assign w_abort     = r_to_flag;
  assign OUT_TIMEOUT = r_out_timeout;
`else
  assign w_to_hit    = 1'b0;
  assign w_abort     = 1'b0;
  assign OUT_TIMEOUT = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; SQ_RESULT is only looked at while waiting on the unit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_next = S_ARM;
        else          w_next = S_IDLE;
      end
      S_ARM:   w_next = S_DRIVE;
      S_DRIVE: begin
        if (r_hold_cnt == HOLD_LAST) w_next = S_WAIT;
        else                         w_next = S_DRIVE;
      end
      S_WAIT: begin
        if (SQ_RESULT || w_to_hit) w_next = S_CAPTURE;
        else                       w_next = S_WAIT;
      end
      S_CAPTURE: w_next = S_PRESENT;
      S_PRESENT: begin
        if (OUT_READY) w_next = S_IDLE;
        else           w_next = S_PRESENT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Counts cycles spent driving the operand onto the bus.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hold_cnt <= 2'd0;
    end else if (r_state == S_DRIVE) begin
      r_hold_cnt <= r_hold_cnt + 2'd1;
    end else begin
      r_hold_cnt <= 2'd0;
    end
  end

  // Head of queue becomes the in-flight operand.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_op <= 16'h0000;
    end else if (w_pop) begin
      r_op <= r_mem[r_rptr];
    end else begin
      r_op <= r_op;
    end
  end

  // Unit enable drops only for the ARM pulse; in IDLE it keeps its last value.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sq_en <= 1'b0;
      r_drive <= 1'b0;
    end else begin
      r_drive <= (w_next == S_DRIVE);
      case (w_next)
        S_ARM:                                  r_sq_en <= 1'b0;
        S_DRIVE, S_WAIT, S_CAPTURE, S_PRESENT:  r_sq_en <= 1'b1;
        default:                                r_sq_en <= r_sq_en;
      endcase
    end
  end

  // Result capture and output handshake.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_out_data  <= 16'h0000;
      r_out_flags <= 3'b000;
      r_out_valid <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      r_out_valid <= 1'b1;
      if (w_abort) begin
        r_out_data  <= 16'h7E00;
        r_out_flags <= 3'b100;
      end else begin
        r_out_data  <= SQ_DATA;
        r_out_flags <= {SQ_IS_NAN, SQ_IS_PINF, SQ_IS_NINF};
      end
    end else if (r_state == S_PRESENT && OUT_READY) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Reset gates the bus driver directly so the bus is freed in the reset cycle itself.
  assign SQ_DATA   = (r_drive && !RESET) ? r_op : 16'bz;
  assign SQ_ENABLE = r_sq_en;
  assign OUT_DATA  = r_out_data;
  assign OUT_FLAGS = r_out_flags;
  assign OUT_VALID = r_out_valid;

endmodule

// File: tb/tb_sqrt2_driver.sv
// Scoreboard bench for sqrt2_driver with a behavioural FP16 sqrt unit on the SQ_* bus.
// Define SQRT_DRV_TIMEOUT_EN for both files to also exercise the watchdog path.
module tb_sqrt2_driver;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] IN_DATA;
  logic        IN_VALID;
  logic        OUT_READY;
  wire         IN_READY;
  wire  [15:0] OUT_DATA;
  wire  [2:0]  OUT_FLAGS;
  wire         OUT_TIMEOUT;
  wire         OUT_VALID;
  wire  [15:0] SQ_DATA;
  wire         SQ_ENABLE;
  wire         SQ_RESULT;
  wire         SQ_IS_NAN;
  wire         SQ_IS_PINF;
  wire         SQ_IS_NINF;

  always #5 CLK = ~CLK;

  sqrt2_driver #(.FIFO_DEPTH(4), .OP_HOLD(1), .TIMEOUT_CYC(64)) dut (
    .CLK(CLK), .RESET(RESET),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_FLAGS(OUT_FLAGS), .OUT_TIMEOUT(OUT_TIMEOUT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .SQ_DATA(SQ_DATA), .SQ_ENABLE(SQ_ENABLE), .SQ_RESULT(SQ_RESULT),
    .SQ_IS_NAN(SQ_IS_NAN), .SQ_IS_PINF(SQ_IS_PINF), .SQ_IS_NINF(SQ_IS_NINF)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference square root in plain real arithmetic: returns {nan, pinf, ninf, result}.
  function automatic logic [18:0] ref_sqrt(input logic [15:0] h);
    logic [4:0] ex;
    logic [9:0] mn;
    real r;
    int  e;
    ex = h[14:10];
    mn = h[9:0];
    if (ex == 5'd31 && mn != 10'd0) return {3'b100, 16'h7E00};
    if (h[14:0] == 15'd0)           return {3'b000, h};
    if (h[15])                      return {3'b100, 16'hFE00};
    if (ex == 5'd31)                return {3'b010, 16'h7C00};
    if (ex == 5'd0) begin
      r = real'(mn) / 1024.0;
      e = -14;
    end else begin
      r = 1.0 + real'(mn) / 1024.0;
      e = int'(ex) - 15;
    end
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    r = $sqrt(r);
    e = 0;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0)  begin r = r * 2.0; e--; end
    return {3'b000, 1'b0, 5'(e + 15), 10'($rtoi((r - 1.0) * 1024.0))};
  endfunction

  // ---------------- behavioural sqrt unit ----------------
  int          u_phase = 0;      // 0 reset/await operand, 2 computing, 3 result held
  int          u_cnt = 0;
  int          u_lat_min = 0;
  int          u_lat_max = 4;
  bit          u_hang = 1'b0;
  logic [15:0] u_op = 16'h0000;
  logic [15:0] u_res = 16'h0000;
  logic [2:0]  u_flg = 3'b000;
  logic        u_garb = 1'b1;

  always @(posedge CLK) begin
    u_garb <= 1'($urandom_range(1, 0));
    if (!SQ_ENABLE) begin
      u_phase <= 0;
    end else begin
      case (u_phase)
        0: begin
          u_op    <= SQ_DATA;
          u_cnt   <= $urandom_range(u_lat_max - 1, u_lat_min);
          u_phase <= 2;
        end
        2: begin
          if (u_cnt == 0 && !u_hang) begin
            u_phase <= 3;
            {u_flg, u_res} <= ref_sqrt(u_op);
          end else if (u_cnt != 0) begin
            u_cnt <= u_cnt - 1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outside its compute phase the unit shows random RESULT/flags, including stale highs in ARM.
  assign SQ_DATA    = (u_phase == 3) ? u_res : 16'bz;
  assign SQ_RESULT  = (u_phase == 3) ? 1'b1 : ((u_phase == 2) ? 1'b0 : u_garb);
  assign SQ_IS_NAN  = (u_phase == 3) ? u_flg[2] : u_garb;
  assign SQ_IS_PINF = (u_phase == 3) ? u_flg[1] : u_garb;
  assign SQ_IS_NINF = (u_phase == 3) ? u_flg[0] : u_garb;

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  f;
    logic        t;
  } exp_t;

  exp_t        exp_q[$];
  bit          hang_next = 1'b0;
  int          n_results = 0;
  int          n_arms = 0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_d = 16'h0000;
  logic [2:0]  prev_f = 3'b000;
  logic        en_prev = 1'b0;
  bit          en_fell = 1'b0;

  always @(negedge CLK) begin
    exp_t        e;
    logic [18:0] rs;
    if (RESET) begin
      exp_q.delete();
      prev_stall = 1'b0;
      en_prev    = 1'b0;
      en_fell    = 1'b0;
    end else begin
      if (prev_stall) begin
        chk(OUT_VALID == 1'b1, "hold_valid", 32'(OUT_VALID), 32'd1);
        chk(OUT_DATA == prev_d && OUT_FLAGS == prev_f, "hold_data",
            {13'd0, OUT_FLAGS, OUT_DATA}, {13'd0, prev_f, prev_d});
      end
      if (OUT_VALID && OUT_READY) begin
        n_results++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_result", 32'(OUT_DATA), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk(OUT_DATA == e.d, "out_data", 32'(OUT_DATA), 32'(e.d));
          chk(OUT_FLAGS == e.f, "out_flags", 32'(OUT_FLAGS), 32'(e.f));
          chk(OUT_TIMEOUT == e.t, "out_timeout", 32'(OUT_TIMEOUT), 32'(e.t));
        end
      end
      prev_stall = OUT_VALID && !OUT_READY;
      prev_d     = OUT_DATA;
      prev_f     = OUT_FLAGS;
      if (IN_VALID && IN_READY) begin
        if (hang_next) begin
          e = '{d: 16'h7E00, f: 3'b100, t: 1'b1};
        end else begin
          rs = ref_sqrt(IN_DATA);
          e  = '{d: rs[15:0], f: rs[18:16], t: 1'b0};
        end
        exp_q.push_back(e);
      end
      if (en_fell) begin
        chk(SQ_ENABLE == 1'b1, "arm_pulse_len", 32'(SQ_ENABLE), 32'd1);
      end
      en_fell = en_prev && !SQ_ENABLE;
      if (en_fell) n_arms++;
      en_prev = SQ_ENABLE;
    end
  end

  // ---------------- output-ready driver ----------------
  int rdy_mode = 1;   // 0 stall, 1 always ready, 2 random
  initial begin
    OUT_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0:       OUT_READY = 1'b0;
        1:       OUT_READY = 1'b1;
        default: OUT_READY = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic [15:0] d, output bit acc);
    IN_DATA  = d;
    IN_VALID = 1'b1;
    @(negedge CLK);
    acc = IN_READY;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic push_until(input logic [15:0] d);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 300 && !acc; k++) push(d, acc);
    if (!acc) chk(1'b0, "push_timeout", 32'(IN_READY), 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 3000; k++) begin
      @(negedge CLK);
      if (exp_q.size() == 0) begin
        repeat (2) @(posedge CLK);
        #1;
        return;
      end
    end
    chk(1'b0, tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    int acc_cnt;
    int res_before;
    int arms_before;
    bit found;

    RESET    = 1'b1;
    IN_VALID = 1'b0;
    IN_DATA  = 16'h0000;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk(IN_READY == 1'b0, "in_ready_in_reset", 32'(IN_READY), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk(OUT_VALID == 1'b0, "rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk(OUT_DATA == 16'h0000, "rst_out_data", 32'(OUT_DATA), 32'd0);
    chk(OUT_FLAGS == 3'b000, "rst_out_flags", 32'(OUT_FLAGS), 32'd0);
    chk(OUT_TIMEOUT == 1'b0, "rst_out_timeout", 32'(OUT_TIMEOUT), 32'd0);
    chk(SQ_ENABLE == 1'b0, "rst_sq_enable", 32'(SQ_ENABLE), 32'd0);
    chk(IN_READY == 1'b1, "rst_in_ready", 32'(IN_READY), 32'd1);
    @(posedge CLK);
    #1;

    // Directed operands: 4.0, -2.0, +inf, then a few specials.
    arms_before = n_arms;
    push_until(16'h4400);
    drain("drain_4p0");
    chk(n_results == 1, "one_result", 32'(n_results), 32'd1);
    push_until(16'hC000);
    push_until(16'h7C00);
    push_until(16'h0000);
    push_until(16'h8000);
    push_until(16'h7E01);
    push_until(16'h0001);
    drain("drain_directed");
    chk(n_arms - arms_before == 6, "arm_count", 32'(n_arms - arms_before), 32'd6);

    // Random operands with random backpressure and gaps.
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(2, 0)) @(posedge CLK);
      #1;
      push_until(16'($urandom));
    end
    drain("drain_random");
    rdy_mode = 1;
    repeat (2) @(posedge CLK);
    #1;

    // Full-queue backpressure: 1 in flight + 4 queued.
    rdy_mode = 0;
    repeat (3) @(posedge CLK);
    #1;
    res_before = n_results;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      push(16'h3C00 + 16'(i * 16'h0400), acc);
      if (acc) acc_cnt++;
    end
    chk(acc_cnt == 5, "accepted_when_full", 32'(acc_cnt), 32'd5);
    @(negedge CLK);
    chk(IN_READY == 1'b0, "in_ready_full", 32'(IN_READY), 32'd0);
    rdy_mode = 1;
    drain("drain_full");
    chk(n_results - res_before == 5, "full_result_count", 32'(n_results - res_before), 32'd5);
    @(negedge CLK);
    chk(IN_READY == 1'b1, "in_ready_after_full", 32'(IN_READY), 32'd1);
    @(posedge CLK);
    #1;

    // Reset while the unit is computing.
    u_lat_min = 12;
    u_lat_max = 20;
    push_until(16'h4900);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge CLK);
      #1;
      if (u_phase == 2) found = 1'b1;
    end
    chk(found, "reach_wait", 32'(found), 32'd1);
    res_before = n_results;
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk(SQ_ENABLE == 1'b0, "midrst_sq_enable", 32'(SQ_ENABLE), 32'd0);
    chk(OUT_VALID == 1'b0, "midrst_out_valid", 32'(OUT_VALID), 32'd0);
    chk(IN_READY == 1'b0, "midrst_in_ready", 32'(IN_READY), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    u_lat_min = 0;
    u_lat_max = 4;
    @(negedge CLK);
    chk(IN_READY == 1'b1, "postrst_in_ready", 32'(IN_READY), 32'd1);
    repeat (10) @(negedge CLK);
    chk(n_results == res_before, "postrst_no_result", 32'(n_results), 32'(res_before));
    chk(SQ_ENABLE == 1'b0, "postrst_queue_empty", 32'(SQ_ENABLE), 32'd0);
    @(posedge CLK);
    #1;
    push_until(16'h5000);
    drain("drain_postrst");
    chk(n_results == res_before + 1, "postrst_recovery", 32'(n_results), 32'(res_before + 1));

`ifdef SQRT_DRV_TIMEOUT_EN
    // Unit never answers: watchdog result, then a normal op.
    u_hang    = 1'b1;
    hang_next = 1'b1;
    push_until(16'h4400);
    hang_next = 1'b0;
    drain("drain_timeout");
    u_hang = 1'b0;
    push_until(16'h4400);
    drain("drain_after_timeout");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks, expected run to finish", n_checks);
    $fatal(1);
  end

endmodule
